op_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one start/done arithmetic unit (e.g. `sub`) among `NREQ` requesters in the calculator datapath. It accepts one operand pair at a time and drives a single-cycle `unit_start` pulse. It waits for `unit_done`, then returns the IEEE754 result and error flag to the granted requester. It sits between the input/control logic and the shared arithmetic unit; a timeout option guards against a unit that never completes.

---
 rtl/op_arbiter_pkg.sv | 22 ++
 rtl/op_arbiter_if.sv | 32 +++
 rtl/op_arbiter_rr_pick.sv | 25 ++
 rtl/op_arbiter.sv | 142 ++++++++++++++
 tb/tb_op_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/op_arbiter_pkg.sv
// Shared calculator-datapath definitions used by op_arbiter and its helpers.
// INPUTOUTBIT sets the operand/result width and defaults to 32 (IEEE754 single).
`ifndef INPUTOUTBIT
`define INPUTOUTBIT 32
`endif

package calc_pkg;

    // Sequencer states of the shared-unit arbiter
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam int WIDTH    = `INPUTOUTBIT;

    // Width of the WAIT-state watchdog counter
    localparam int TO_CNT_W = 8;

endpackage

// File: rtl/op_arbiter_if.sv
// Requester-side and unit-side bus of op_arbiter.
// slave: the arbiter; master: requesters plus the arithmetic unit (or a bench).
interface op_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = calc_pkg::WIDTH
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       resp_valid;
    logic [WIDTH-1:0]      resp_result;
    logic                  resp_error;
    logic                  unit_start;
    logic [WIDTH-1:0]      unit_a;
    logic [WIDTH-1:0]      unit_b;
    logic [WIDTH-1:0]      unit_result;
    logic                  unit_error;
    logic                  unit_done;

    modport slave (
        input  req_valid, req_a, req_b, unit_result, unit_error, unit_done,
        output req_ready, resp_valid, resp_result, resp_error,
               unit_start, unit_a, unit_b
    );

    modport master (
        output req_valid, req_a, req_b, unit_result, unit_error, unit_done,
        input  req_ready, resp_valid, resp_result, resp_error,
               unit_start, unit_a, unit_b
    );
endinterface

// File: rtl/op_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant of the first request found searching
// upward from ptr+1 and wrapping, so the requester at ptr has lowest priority.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic            any
);
    // Scan farthest-to-nearest so the nearest request after ptr wins last
    always_comb begin
        grant = '0;
        any   = |req;
        for (int k = NREQ; k >= 1; k--) begin
            logic [PW-1:0] idx;
            idx = PW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/op_arbiter.sv
// op_arbiter: shares one start/done arithmetic unit among NREQ requesters.
// Sequence per operation: IDLE (accept) -> ISSUE (start pulse) -> WAIT (for
// unit_done) -> RESP (one-hot response strobe) -> IDLE.
// Optional macro OP_ARB_TIMEOUT_EN adds a WAIT watchdog that answers with
// result 0 / error 1 after TIMEOUT cycles without unit_done.
module op_arbiter
    import calc_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = calc_pkg::WIDTH,
    parameter int TIMEOUT = 255
) (
    input logic         clk,
    input logic         rst,
    op_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("op_arbiter: NREQ must be in 2..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("op_arbiter: TIMEOUT must be in 1..255");
    end

    arb_state_t       state;
    logic [NREQ-1:0]  pick;
    logic             any_req;
    logic [NREQ-1:0]  gnt_q;
    logic [PW-1:0]    gnt_idx;
    logic [PW-1:0]    ptr;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             err_q;
    logic             start_q;
    logic [NREQ-1:0]  resp_q;
`ifdef OP_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt;
`endif

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (pick),
        .any   (any_req)
    );

    // Operand mux for whichever requester the picker selected
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                a_sel = bus.req_a[i*WIDTH +: WIDTH];
                b_sel = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Binary index of the latched grant, becomes the new pointer in RESP
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) gnt_idx = PW'(i);
        end
    end

    // Accept is combinational so a requester sees it in its request cycle
    assign bus.req_ready   = (state == ST_IDLE) ? pick : '0;
    assign bus.unit_start  = start_q;
    assign bus.unit_a      = a_q;
    assign bus.unit_b      = b_q;
    assign bus.resp_valid  = resp_q;
    assign bus.resp_result = res_q;
    assign bus.resp_error  = err_q;

    // Sequencer FSM; start and response strobes are registered one-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= PW'(NREQ - 1);
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            resp_q  <= '0;
`ifdef OP_ARB_TIMEOUT_EN
            to_cnt  <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            resp_q  <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_q   <= pick;
                        a_q     <= a_sel;
                        b_q     <= b_sel;
                        start_q <= 1'b1;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef OP_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done in the expiry cycle wins over the watchdog
                    if (bus.unit_done) begin
                        res_q  <= bus.unit_result;
                        err_q  <= bus.unit_error;
                        resp_q <= gnt_q;
                        state  <= ST_RESP;
                    end
`ifdef OP_ARB_TIMEOUT_EN
                    else if (to_cnt == TO_CNT_W'(TIMEOUT - 1)) begin
                        to_cnt <= to_cnt + 1'b1;
                        res_q  <= '0;
                        err_q  <= 1'b1;
                        resp_q <= gnt_q;
                        state  <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    ptr   <= gnt_idx;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_op_arbiter.sv
// Bench for op_arbiter: directed literal cases plus a randomized phase, all
// checked every cycle against a timeline model of the arbiter's behaviour.
`timescale 1ns/1ps
module tb_op_arbiter;
    import calc_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = calc_pkg::WIDTH;
`ifdef OP_ARB_TIMEOUT_EN
    localparam int TMO  = 8;
`else
    localparam int TMO  = 255;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    op_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

    op_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Integer -> IEEE754 single (truncating), the bench's `sub` unit arithmetic
    function automatic logic [31:0] i2f(input int v);
        logic [31:0] m;
        logic [31:0] man;
        int e;
        if (v == 0) return 32'h0;
        m = (v < 0) ? 32'(-v) : 32'(v);
        e = 0;
        for (int k = 0; k < 32; k++) if (m[k]) e = k;
        man = (e <= 23) ? (m << (23 - e)) : (m >> (e - 23));
        return {(v < 0), 8'(e + 127), man[22:0]};
    endfunction

    function automatic logic [W:0] unit_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        return {(d < -1000), W'(i2f(d))};
    endfunction

    // ---------------- bench-side unit and requesters ----------------
    bit              st_seen = 0;
    logic [NREQ-1:0] acc = '0;
    bit              u_busy = 0, u_tie0 = 0, u_spur = 0, lat_rand = 0, rnd_en = 0;
    int              u_cnt = 0, u_lat = 1;
    logic [W-1:0]    u_a, u_b;

    task automatic unit_drive();
        bus.unit_done   = 1'b0;
        bus.unit_result = '0;
        bus.unit_error  = 1'b0;
        if (st_seen && !u_tie0) begin
            if (lat_rand) u_lat = $urandom_range(1, 9);
            u_busy = 1;
            u_cnt  = u_lat - 1;
            u_a    = bus.unit_a;
            u_b    = bus.unit_b;
        end
        if (u_busy) begin
            if (u_cnt == 0) begin
                {bus.unit_error, bus.unit_result} = unit_fn(u_a, u_b);
                bus.unit_done = 1'b1;
                u_busy = 0;
            end else u_cnt--;
        end else if (u_spur && $urandom_range(0, 5) == 0) begin
            bus.unit_done   = 1'b1;
            bus.unit_result = W'($urandom);
            bus.unit_error  = 1'b1;
        end
    endtask

    task automatic req_drive();
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && acc[i]) begin
                bus.req_valid[i] = ($urandom_range(0, 1) == 0);
            end else if (bus.req_valid[i] && $urandom_range(0, 15) == 0) begin
                bus.req_valid[i] = 1'b0;
            end else if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
                bus.req_valid[i]        = 1'b1;
                bus.req_a[i*W +: W]     = W'($urandom_range(0, 4000)) - W'(2000);
                bus.req_b[i*W +: W]     = W'($urandom_range(0, 4000)) - W'(2000);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        unit_drive();
        if (rnd_en) req_drive();
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    int              cyc = 0;
    bit              m_rst_pend = 1;
    bit              m_busy = 0;
    int              m_ptr = NREQ - 1;
    int              m_g = 0, m_start = -10, m_resp = -1;
    logic [W-1:0]    m_a, m_b, m_res;
    logic            m_err;
    bit              prev_start = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready, exp_resp;
        logic            exp_start;
        cyc++;
        st_seen = bus.unit_start;
        acc     = bus.req_ready;
        if (m_rst_pend) begin
            m_busy = 0;
            m_ptr  = NREQ - 1;
            m_resp = -1;
            m_start = -10;
        end
        m_rst_pend = rst;

        exp_ready = '0;
        exp_resp  = '0;
        exp_start = 1'b0;
        if (!m_busy) begin
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (bus.req_valid[idx] && exp_ready == '0) begin
                    exp_ready[idx] = 1'b1;
                    m_g = idx;
                end
            end
            if (exp_ready != '0) begin
                m_busy  = 1;
                m_a     = bus.req_a[m_g*W +: W];
                m_b     = bus.req_b[m_g*W +: W];
                m_start = cyc + 1;
                m_resp  = -1;
            end
        end else begin
            if (cyc == m_start) exp_start = 1'b1;
            if (cyc > m_start && m_resp < 0) begin
                if (bus.unit_done) begin
                    m_resp = cyc + 1;
                    {m_err, m_res} = unit_fn(m_a, m_b);
                end
`ifdef OP_ARB_TIMEOUT_EN
                else if (cyc - m_start == TMO) begin
                    m_resp = cyc + 1;
                    m_err  = 1'b1;
                    m_res  = '0;
                end
`endif
            end
            if (cyc == m_resp) exp_resp[m_g] = 1'b1;
        end

        chk("req_ready", bus.req_ready, exp_ready);
        chk("unit_start", bus.unit_start, exp_start);
        chk("start_b2b", bus.unit_start & prev_start, 0);
        chk("resp_valid", bus.resp_valid, exp_resp);
        if (exp_resp != '0) begin
            chk("resp_result", bus.resp_result, m_res);
            chk("resp_error", bus.resp_error, m_err);
        end
        if (m_busy && cyc >= m_start && (m_resp < 0 || cyc < m_resp)) begin
            chk("unit_a", bus.unit_a, m_a);
            chk("unit_b", bus.unit_b, m_b);
        end
        prev_start = bus.unit_start;
        if (m_busy && cyc == m_resp) begin
            m_busy = 0;
            m_ptr  = m_g;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic pulse_reset();
        tick();
        rst = 1'b1;
        bus.req_valid = '0;
        u_busy = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        rnd_en = 0;
        bus.req_valid = '0;
        repeat (20) tick();
    endtask

    task automatic dir_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input string nm);
        bit found;
        int k;
        tick();
        bus.req_valid[i]    = 1'b1;
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        @(negedge clk);
        chk({nm, "_ready"}, bus.req_ready, 1 << i);
        tick();
        bus.req_valid[i] = 1'b0;
        @(negedge clk);
        chk({nm, "_start"}, bus.unit_start, 1);
        k = 1;
        found = 0;
        for (int n = 0; n < 50 && !found; n++) begin
            tick();
            @(negedge clk);
            k++;
            if (bus.resp_valid != '0) begin
                found = 1;
                chk({nm, "_latency"}, k, 3);
                chk({nm, "_rvalid"}, bus.resp_valid, 1 << i);
                chk({nm, "_result"}, bus.resp_result, exp_res);
                chk({nm, "_error"}, bus.resp_error, 0);
            end
        end
        if (!found) chk({nm, "_no_response"}, 0, 1);
    endtask

    task automatic grant_seq(input logic [NREQ-1:0] mask, input int eg [5], input string nm);
        int g [5];
        int gc [5];
        int ng;
        tick();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = W'(i + 1);
            bus.req_b[i*W +: W] = '0;
        end
        bus.req_valid = mask;
        ng = 0;
        for (int n = 0; n < 60 && ng < 5; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g[ng] = i;
                gc[ng] = n;
                ng++;
            end
            tick();
        end
        chk({nm, "_count"}, ng, 5);
        for (int j = 0; j < ng; j++) begin
            chk({nm, "_grant"}, g[j], eg[j]);
            if (j > 0) chk({nm, "_spacing"}, gc[j] - gc[j-1], 4);
        end
        drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int nresp;
        int k;
        bit found;
        bus.req_valid   = '0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.unit_done   = 1'b0;
        bus.unit_result = '0;
        bus.unit_error  = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_unit_start", bus.unit_start, 0);
        chk("rst_unit_a", bus.unit_a, 0);
        chk("rst_resp_result", bus.resp_result, 0);

        dir_op(0, W'(10), W'(3), 32'h40E00000, "sub_10_3");
        dir_op(2, W'(3), W'(10), 32'hC0E00000, "sub_3_10");
        dir_op(1, W'(5), W'(5), 32'h00000000, "sub_5_5");
        drain();

        pulse_reset();
        grant_seq(4'hF, '{0, 1, 2, 3, 0}, "all4");
        pulse_reset();
        grant_seq(4'h9, '{0, 3, 0, 3, 0}, "r0r3");

        // reset while WAITing for a slow unit
        u_lat = 6;
        tick();
        bus.req_valid[1] = 1'b1;
        @(negedge clk);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        u_busy = 0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("wrst_unit_start", bus.unit_start, 0);
        chk("wrst_resp_valid", bus.resp_valid, 0);
        chk("wrst_unit_a", bus.unit_a, 0);
        chk("wrst_unit_b", bus.unit_b, 0);
        chk("wrst_result", {bus.resp_error, bus.resp_result}, 0);
        chk("wrst_ready", bus.req_ready, 0);
        nresp = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            @(negedge clk);
            if (bus.resp_valid != '0) nresp++;
        end
        chk("wrst_no_resp", nresp, 0);
        u_lat = 1;
        grant_seq(4'h9, '{0, 3, 0, 3, 0}, "post_rst");

        // unit that never completes
        u_tie0 = 1;
        tick();
        bus.req_valid[2]    = 1'b1;
        bus.req_a[2*W +: W] = W'(9);
        @(negedge clk);
        chk("hang_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("hang_start", bus.unit_start, 1);
`ifdef OP_ARB_TIMEOUT_EN
        k = 0;
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            tick();
            @(negedge clk);
            k++;
            if (bus.resp_valid != '0) begin
                found = 1;
                chk("tmo_latency", k, 9);
                chk("tmo_rvalid", bus.resp_valid, 4'b0100);
                chk("tmo_error", bus.resp_error, 1);
                chk("tmo_result", bus.resp_result, 0);
            end
        end
        if (!found) chk("tmo_no_response", 0, 1);
`else
        k = 0;
        found = 0;
        nresp = 0;
        for (int n = 0; n < 1000; n++) begin
            tick();
            @(negedge clk);
            if (bus.resp_valid != '0) nresp++;
        end
        chk("hang_no_resp", nresp, 0);
`endif
        u_tie0 = 0;
        pulse_reset();
        drain();

        // randomized traffic, variable unit latency, stray done pulses
        lat_rand = 1;
        u_spur   = 1;
        rnd_en   = 1;
        repeat (3000) tick();
        u_spur   = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
